// File: rtl/alu_pkg.sv
// Shared constants, instruction layout and op helpers for the ALU issue stage.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int OP_W      = 6;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int IMM_W     = 15;

  localparam logic [OP_W-1:0] NUM_OPS = 6'd6;

  localparam logic [OP_W-1:0] OP_ADD = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB = 6'd1;
  localparam logic [OP_W-1:0] OP_AND = 6'd2;
  localparam logic [OP_W-1:0] OP_OR  = 6'd3;
  localparam logic [OP_W-1:0] OP_SRL = 6'd4;
  localparam logic [OP_W-1:0] OP_SLL = 6'd5;

  // Field order mirrors instr[31:0]; rt occupies imm[14:10] when use_imm is clear.
  typedef struct packed {
    logic [OP_W-1:0]      op;       // [31:26]
    logic [REG_IDX_W-1:0] rd;       // [25:21]
    logic [REG_IDX_W-1:0] rs;       // [20:16]
    logic                 use_imm;  // [15]
    logic [IMM_W-1:0]     imm;      // [14:0]
  } instr_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op < NUM_OPS);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port; r0 always reads zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [REG_IDX_W-1:0] raddr_a_i,
  input  logic [REG_IDX_W-1:0] raddr_b_i,
  input  logic [REG_IDX_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]    rdata_a_o,
  output logic [DATA_W-1:0]    rdata_b_o,
  output logic [DATA_W-1:0]    dbg_data_o
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Storage: synchronous clear, single write port, r0 never written.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i && (waddr_i != {REG_IDX_W{1'b0}})) begin
      regs_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == {REG_IDX_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == {REG_IDX_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == {REG_IDX_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around an external combinational ALU: decodes, reads
// operands with single-path forwarding, registers ALU inputs, writes back.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [31:0]          instr_i,
  input  logic                 stall_i,
  output logic [DATA_W-1:0]    alu_in0_o,
  output logic [DATA_W-1:0]    alu_in1_o,
  output logic [OP_W-1:0]      alu_op_o,
  input  logic [DATA_W-1:0]    alu_out_i,
  output logic                 wb_valid_o,
  output logic [REG_IDX_W-1:0] wb_rd_o,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic                 illegal_o,
  input  logic [REG_IDX_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]    dbg_data_o
);

  instr_t               instr_s;
  logic [REG_IDX_W-1:0] rt_s;
  logic [DATA_W-1:0]    imm_ext_s;
  logic [DATA_W-1:0]    rf_a_s;
  logic [DATA_W-1:0]    rf_b_s;
  logic [DATA_W-1:0]    opa_s;
  logic [DATA_W-1:0]    opb_s;
  logic                 accept_s;
  logic                 wb_fire_s;
  logic                 fwd_en_s;

  logic                 ex_valid_r;
  logic                 ex_illegal_r;
  logic [REG_IDX_W-1:0] rd_q_r;

  assign instr_s       = instr_t'(instr_i);
  assign rt_s          = instr_s.imm[IMM_W-1 -: REG_IDX_W];
  assign imm_ext_s     = {{(DATA_W-IMM_W){1'b0}}, instr_s.imm};
  assign instr_ready_o = rst_i & ~stall_i;
  assign accept_s      = instr_valid_i & instr_ready_o;
  assign wb_fire_s     = ex_valid_r & ~ex_illegal_r & ~stall_i;
  // Only a write actually landing this edge may be forwarded.
  assign fwd_en_s      = wb_fire_s & (rd_q_r != {REG_IDX_W{1'b0}});

  alu_regfile u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (wb_fire_s),
    .waddr_i    (rd_q_r),
    .wdata_i    (alu_out_i),
    .raddr_a_i  (instr_s.rs),
    .raddr_b_i  (rt_s),
    .dbg_addr_i (dbg_addr_i),
    .rdata_a_o  (rf_a_s),
    .rdata_b_o  (rf_b_s),
    .dbg_data_o (dbg_data_o)
  );

  // Operand select: register file, immediate, or the in-flight ALU result.
  always_comb begin
    opa_s = rf_a_s;
    opb_s = rf_b_s;
    if (fwd_en_s && (instr_s.rs == rd_q_r)) begin
      opa_s = alu_out_i;
    end else begin
      opa_s = rf_a_s;
    end
    if (instr_s.use_imm) begin
      opb_s = imm_ext_s;
    end else if (fwd_en_s && (rt_s == rd_q_r)) begin
      opb_s = alu_out_i;
    end else begin
      opb_s = rf_b_s;
    end
  end

  // Pipeline state: ID->EX capture and EX retirement pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_r   <= 1'b0;
      ex_illegal_r <= 1'b0;
      rd_q_r       <= {REG_IDX_W{1'b0}};
      alu_in0_o    <= {DATA_W{1'b0}};
      alu_in1_o    <= {DATA_W{1'b0}};
      alu_op_o     <= {OP_W{1'b0}};
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= {REG_IDX_W{1'b0}};
      wb_data_o    <= {DATA_W{1'b0}};
      illegal_o    <= 1'b0;
    end else if (stall_i) begin
      wb_valid_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      wb_valid_o <= ex_valid_r & ~ex_illegal_r;
      illegal_o  <= ex_valid_r & ex_illegal_r;
      if (wb_fire_s) begin
        wb_rd_o   <= rd_q_r;
        wb_data_o <= alu_out_i;
      end
      if (accept_s) begin
        alu_in0_o    <= opa_s;
        alu_in1_o    <= opb_s;
        alu_op_o     <= instr_s.op;
        rd_q_r       <= instr_s.rd;
        ex_illegal_r <= ~op_is_legal(instr_s.op);
        ex_valid_r   <= 1'b1;
      end else begin
        ex_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench: directed scenarios then random traffic against an
// in-order architectural model of the issue stage and register file.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic        stall_i;
  logic [31:0] alu_in0_o;
  logic [31:0] alu_in1_o;
  logic [5:0]  alu_op_o;
  logic [31:0] alu_out_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        illegal_o;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: arch_rf reflects every accepted instruction in program order,
  // commit_rf only what has actually been written back.
  logic [31:0] arch_rf   [32];
  logic [31:0] commit_rf [32];
  logic        pend_v, pend_ill;
  logic [4:0]  pend_rd;
  logic [31:0] pend_data;
  logic        exp_wb_v, exp_ill;
  logic [4:0]  exp_wb_rd;
  logic [31:0] exp_wb_data, exp_in0, exp_in1;
  logic [5:0]  exp_op;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .stall_i       (stall_i),
    .alu_in0_o     (alu_in0_o),
    .alu_in1_o     (alu_in1_o),
    .alu_op_o      (alu_op_o),
    .alu_out_i     (alu_out_i),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .illegal_o     (illegal_o),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_data_o    (dbg_data_o)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return (b >= 32'd32) ? 32'd0 : (a >> b[4:0]);
      6'd5:    return (b >= 32'd32) ? 32'd0 : (a << b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_out_i = alu_fn(alu_op_o, alu_in0_o, alu_in1_o);

  function automatic logic [31:0] ii(input int op, input int rd, input int rs, input int imm);
    return {6'(op), 5'(rd), 5'(rs), 1'b1, 15'(imm)};
  endfunction

  function automatic logic [31:0] ri(input int op, input int rd, input int rs, input int rt);
    return {6'(op), 5'(rd), 5'(rs), 1'b0, 5'(rt), 10'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [31:0] expv);
    dbg_addr_i = 5'(idx);
    #1;
    chk(tag, dbg_data_o, expv);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      arch_rf[i]   = 32'd0;
      commit_rf[i] = 32'd0;
    end
    pend_v = 1'b0; pend_ill = 1'b0; pend_rd = 5'd0; pend_data = 32'd0;
    exp_wb_v = 1'b0; exp_ill = 1'b0; exp_wb_rd = 5'd0; exp_wb_data = 32'd0;
    exp_in0 = 32'd0; exp_in1 = 32'd0; exp_op = 6'd0;
  endtask

  // One clock: drive, advance the model across the edge, compare everything.
  task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic rst, input int dbg);
    logic [5:0]  op;
    logic [4:0]  rd, rs, rt;
    logic [31:0] a, b;
    instr_valid_i = v;
    instr_i       = ins;
    stall_i       = st;
    rst_i         = rst;
    dbg_addr_i    = 5'(dbg);
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else if (!st) begin
      exp_wb_v = 1'b0;
      exp_ill  = 1'b0;
      if (pend_v && pend_ill) begin
        exp_ill = 1'b1;
      end else if (pend_v) begin
        exp_wb_v    = 1'b1;
        exp_wb_rd   = pend_rd;
        exp_wb_data = pend_data;
        if (pend_rd != 5'd0) commit_rf[pend_rd] = pend_data;
      end
      pend_v = 1'b0;
      if (v) begin
        op = ins[31:26]; rd = ins[25:21]; rs = ins[20:16]; rt = ins[14:10];
        a  = arch_rf[rs];
        b  = ins[15] ? {17'd0, ins[14:0]} : arch_rf[rt];
        exp_in0 = a; exp_in1 = b; exp_op = op;
        pend_v    = 1'b1;
        pend_ill  = (op >= 6'd6);
        pend_rd   = rd;
        pend_data = alu_fn(op, a, b);
        if (!pend_ill && rd != 5'd0) arch_rf[rd] = pend_data;
      end
    end else begin
      exp_wb_v = 1'b0;
      exp_ill  = 1'b0;
    end
    #1;
    chk("ready",    32'(instr_ready_o), 32'(rst & ~st));
    chk("wb_valid", 32'(wb_valid_o),    32'(exp_wb_v));
    chk("wb_rd",    32'(wb_rd_o),       32'(exp_wb_rd));
    chk("wb_data",  wb_data_o,          exp_wb_data);
    chk("illegal",  32'(illegal_o),     32'(exp_ill));
    chk("alu_in0",  alu_in0_o,          exp_in0);
    chk("alu_in1",  alu_in1_o,          exp_in1);
    chk("alu_op",   32'(alu_op_o),      32'(exp_op));
    chk("dbg_data", dbg_data_o,         commit_rf[dbg]);
  endtask

  initial begin
    logic        v, st, rst;
    int          op, imm;
    logic [31:0] ins;

    model_clear();
    rst_i = 1'b0; instr_valid_i = 1'b0; instr_i = 32'd0; stall_i = 1'b0; dbg_addr_i = 5'd0;

    // Reset sweep: every debug index reads zero, ready held low.
    for (int i = 0; i < 32; i++) step(1'b0, 32'd0, 1'b0, 1'b0, i);
    step(1'b0, 32'd0, 1'b0, 1'b1, 0);

    // Immediate loads and a back-to-back dependent chain.
    step(1'b1, ii(0, 1, 0, 5), 1'b0, 1'b1, 1);
    step(1'b1, ii(0, 2, 0, 7), 1'b0, 1'b1, 2);
    chk("ld1_rd", 32'(wb_rd_o), 32'd1);
    chk("ld1_data", wb_data_o, 32'd5);
    step(1'b1, ii(0, 3, 1, 3), 1'b0, 1'b1, 1);
    chk("ld2_rd", 32'(wb_rd_o), 32'd2);
    chk("ld2_data", wb_data_o, 32'd7);
    step(1'b1, ri(1, 4, 3, 1), 1'b0, 1'b1, 3);
    chk("haz1_data", wb_data_o, 32'd8);
    step(1'b0, 32'd0, 1'b0, 1'b1, 4);
    chk("haz2_valid", 32'(wb_valid_o), 32'd1);
    chk("haz2_data", wb_data_o, 32'd3);
    chk_reg("r1", 1, 32'd5);
    chk_reg("r2", 2, 32'd7);
    chk_reg("r3", 3, 32'd8);
    chk_reg("r4", 4, 32'd3);

    // Write to r0 pulses but leaves r0 zero; illegal op retires silently.
    step(1'b1, ii(0, 0, 0, 9), 1'b0, 1'b1, 0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 0);
    chk("r0_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("r0_wb_data", wb_data_o, 32'd9);
    chk_reg("r0_zero", 0, 32'd0);
    step(1'b1, ii(7, 1, 0, 1), 1'b0, 1'b1, 1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    chk("ill_pulse", 32'(illegal_o), 32'd1);
    chk("ill_no_wb", 32'(wb_valid_o), 32'd0);
    chk_reg("ill_r1", 1, 32'd5);

    // Stall with a pending shift and a dependent instruction waiting.
    step(1'b1, ii(5, 5, 1, 4), 1'b0, 1'b1, 5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ii(0, 7, 5, 0), 1'b1, 1'b1, 5);
      chk("stall_ready", 32'(instr_ready_o), 32'd0);
      chk("stall_no_wb", 32'(wb_valid_o), 32'd0);
    end
    step(1'b1, ii(0, 7, 5, 0), 1'b0, 1'b1, 5);
    chk("stall_wb_rd", 32'(wb_rd_o), 32'd5);
    chk("stall_wb_data", wb_data_o, 32'd80);
    chk("stall_fwd_in0", alu_in0_o, 32'd80);
    step(1'b0, 32'd0, 1'b0, 1'b1, 7);
    chk_reg("r7", 7, 32'd80);

    // Reset while an instruction sits in EX.
    step(1'b1, ii(0, 6, 0, 1), 1'b0, 1'b1, 6);
    step(1'b0, 32'd0, 1'b0, 1'b0, 6);
    chk("rst_no_wb", 32'(wb_valid_o), 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 6);
    chk("rst_no_wb2", 32'(wb_valid_o), 32'd0);
    chk_reg("r6", 6, 32'd0);

    // Random traffic with dense register reuse.
    for (int n = 0; n < 600; n++) begin
      op  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 63)) : int'($urandom_range(0, 5));
      imm = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 32767));
      ins = ($urandom_range(0, 1) == 0) ? ii(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm)
                                        : ri(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      v   = ($urandom_range(0, 9) < 8);
      st  = ($urandom_range(0, 9) < 2);
      rst = ($urandom_range(0, 49) != 0);
      step(v, ins, st, rst, int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
